// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 bus driver and init sequencer.
//   - FSM state encoding for lcd_bus_driver
//   - poll sub-phase encoding (used when LCD_BUSY_POLL_EN is defined)
//   - HD44780 opcode constants and default bus/execution timing at 50 MHz
//   - is_long_cmd(): identifies Clear Display / Return Home
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4,
        ST_POLL  = 3'd5
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_EN    = 2'd1,
        PH_HOLD  = 2'd2
    } poll_phase_e;

    localparam logic [7:0] LCD_OP_CLEAR = 8'h01;
    localparam logic [7:0] LCD_OP_HOME  = 8'h02;

    localparam int unsigned LCD_SETUP_CYC     = 2;
    localparam int unsigned LCD_EN_CYC        = 12;
    localparam int unsigned LCD_HOLD_CYC      = 2;
    localparam int unsigned LCD_EXEC_CYC      = 2000;
    localparam int unsigned LCD_EXEC_LONG_CYC = 82000;
    localparam int unsigned LCD_CNT_W         = 17;

    // Instruction bytes 0x00..0x03: Clear (0x01) and Return Home (0x02/0x03,
    // bit 0 is don't-care). 0x00 shares the same decode and gets the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        logic [7:0] d1;
        d1 = data | 8'h01;
        return !rs && ((d1 == (LCD_OP_CLEAR | 8'h01)) || (d1 == (LCD_OP_HOME | 8'h01)));
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter with terminal-count (zero) flag.
//   Clock       in   system clock
//   Reset       in   asynchronous, active-high
//   load_i      in   load load_val_i this cycle (has priority over counting)
//   load_val_i  in   value to load; a load of N-1 gives N cycles until zero_o
//   zero_o      out  counter is at zero (counting stops there)
module lcd_delay_timer
    import lcd_pkg::*;
#(
    parameter int unsigned CNT_W = LCD_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: HD44780 8-bit parallel bus stage. Takes one byte (RS + data)
// per valid/ready handshake, drives setup / EN pulse / hold on the bus, then
// waits out the controller execution time before accepting the next byte.
//   Clock, Reset        50 MHz clock, asynchronous active-high reset
//   cmd_valid/cmd_ready request handshake; cmd_ready = (state == IDLE)
//   cmd_rs, cmd_data    register select (1 = data) and byte to write
//   busy                high from acceptance until return to IDLE
//   done                one-cycle pulse in the IDLE cycle after a request
//   LCD_EN/RS/RW/DATA   bus outputs, all registered
// Optional feature, macro LCD_BUSY_POLL_EN: replaces the fixed execution wait
// with busy-flag polling. Adds LCD_DATA_IN (bus read value), LCD_DATA_OE
// (1 = drive LCD_DATA) and poll_timeout (sticky, cleared by Reset).
//
// state    | meaning
// IDLE     | waiting for request, cmd_ready high
// SETUP    | RS/RW/DATA settling before EN rises
// EN_HI    | EN high
// HOLD     | EN low, RS/DATA held
// EXEC     | fixed execution wait (normal or long)
// POLL     | busy-flag read cycles (LCD_BUSY_POLL_EN only)
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = LCD_SETUP_CYC,
    parameter int unsigned EN_CYC        = LCD_EN_CYC,
    parameter int unsigned HOLD_CYC      = LCD_HOLD_CYC,
    parameter int unsigned EXEC_CYC      = LCD_EXEC_CYC,
    parameter int unsigned EXEC_LONG_CYC = LCD_EXEC_LONG_CYC,
    parameter int unsigned CNT_W         = LCD_CNT_W
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
`ifdef LCD_BUSY_POLL_EN
    ,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_DATA_OE,
    output logic       poll_timeout
`endif
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(EXEC_LONG_CYC - 1);
`ifndef LCD_BUSY_POLL_EN
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
`endif

    lcd_state_e       state_q;
    logic             en_q;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

`ifdef LCD_BUSY_POLL_EN
    poll_phase_e      phase_q;
    logic [CNT_W-1:0] poll_cnt_q;
    logic             rw_q;
    logic             oe_q;
    logic             db7_q;
    logic             timeout_q;
`else
    logic             long_q;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && (state_q == ST_IDLE);

    lcd_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Timer is reloaded on every state (and poll phase) entry.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_EN;
                end
            end
            ST_EN_HI: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
`ifdef LCD_BUSY_POLL_EN
                    tmr_val  = LD_SETUP;
`else
                    tmr_val  = long_q ? LD_LONG : LD_EXEC;
`endif
                end
            end
`ifdef LCD_BUSY_POLL_EN
            ST_POLL: begin
                if (tmr_zero) begin
                    unique case (phase_q)
                        PH_SETUP: begin
                            tmr_load = 1'b1;
                            tmr_val  = LD_EN;
                        end
                        PH_EN: begin
                            tmr_load = 1'b1;
                            tmr_val  = LD_HOLD;
                        end
                        PH_HOLD: begin
                            tmr_load = db7_q;
                            tmr_val  = LD_SETUP;
                        end
                        default: ;
                    endcase
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            phase_q    <= PH_SETUP;
            poll_cnt_q <= '0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b1;
            db7_q      <= 1'b0;
            timeout_q  <= 1'b0;
`else
            long_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rs_q    <= cmd_rs;
                        data_q  <= cmd_data;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
`ifndef LCD_BUSY_POLL_EN
                        long_q  <= is_long_cmd(cmd_rs, cmd_data);
`endif
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) begin
                        en_q    <= 1'b1;
                        state_q <= ST_EN_HI;
                    end
                end
                ST_EN_HI: begin
                    if (tmr_zero) begin
                        en_q    <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
`ifdef LCD_BUSY_POLL_EN
                        // Turn the bus around for a busy-flag read.
                        rw_q       <= 1'b1;
                        rs_q       <= 1'b0;
                        oe_q       <= 1'b0;
                        phase_q    <= PH_SETUP;
                        poll_cnt_q <= '0;
                        state_q    <= ST_POLL;
`else
                        state_q    <= ST_EXEC;
`endif
                    end
                end
                ST_EXEC: begin
                    if (tmr_zero) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_POLL: begin
`ifdef LCD_BUSY_POLL_EN
                    poll_cnt_q <= poll_cnt_q + 1'b1;
                    if (poll_cnt_q == LD_LONG) begin
                        // Controller never released busy: give up and
                        // leave a sticky flag for the sequencer.
                        en_q      <= 1'b0;
                        rw_q      <= 1'b0;
                        oe_q      <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (tmr_zero) begin
                        unique case (phase_q)
                            PH_SETUP: begin
                                en_q    <= 1'b1;
                                phase_q <= PH_EN;
                            end
                            PH_EN: begin
                                // Last EN-high cycle: read data is valid.
                                db7_q   <= LCD_DATA_IN[7];
                                en_q    <= 1'b0;
                                phase_q <= PH_HOLD;
                            end
                            PH_HOLD: begin
                                if (db7_q) begin
                                    phase_q <= PH_SETUP;
                                end else begin
                                    rw_q    <= 1'b0;
                                    oe_q    <= 1'b1;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_IDLE;
                                end
                            end
                            default: phase_q <= PH_SETUP;
                        endcase
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign LCD_EN   = en_q;
    assign LCD_RS   = rs_q;
    assign LCD_DATA = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef LCD_BUSY_POLL_EN
    assign LCD_RW       = rw_q;
    assign LCD_DATA_OE  = oe_q;
    assign poll_timeout = timeout_q;
`else
    assign LCD_RW = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver. The long execution wait is shortened
// to keep the run short; all expectations are derived from the bench's own
// timing constants.
module tb_lcd_bus_driver;

    localparam int SETUP = 2;
    localparam int ENC   = 12;
    localparam int HOLD  = 2;
    localparam int EXEC  = 2000;
    localparam int LONG  = 5000;

    logic       Clock;
    logic       Reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       busy;
    logic       done;
    logic       LCD_EN;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
`ifdef LCD_BUSY_POLL_EN
    logic [7:0] lcd_data_in;
    logic       lcd_data_oe;
    logic       poll_timeout;
    int         rd_rises;
    // Busy flag model: busy during read pulses 1..3, released on the 4th.
    assign lcd_data_in = {(rd_rises <= 3), 7'h00};
`endif

    int n_checks = 0;
    int n_errors = 0;

    lcd_bus_driver #(
        .SETUP_CYC     (SETUP),
        .EN_CYC        (ENC),
        .HOLD_CYC      (HOLD),
        .EXEC_CYC      (EXEC),
        .EXEC_LONG_CYC (LONG),
        .CNT_W         (17)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .done      (done),
        .LCD_EN    (LCD_EN),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA)
`ifdef LCD_BUSY_POLL_EN
        ,
        .LCD_DATA_IN  (lcd_data_in),
        .LCD_DATA_OE  (lcd_data_oe),
        .poll_timeout (poll_timeout)
`endif
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       is_long;
        string      name;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after the accept edge.
    task automatic send(input logic rs, input logic [7:0] d, input string nm);
        chk({nm, "_ready_before"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = d;
        @(negedge Clock);
        cmd_valid = 1'b0;
    endtask

    // Called at the first negedge after the accept edge (k = 1). Follows the
    // request until done, with a bounded cycle budget.
    task automatic watch(input logic rs, input logic [7:0] d, input int exp_done, input string nm);
        int k, en_first, en_cnt, rises, ready_hi, busy_lo, bad_data;
        logic en_prev, got_done;
        k = 1; en_first = 0; en_cnt = 0; rises = 0; ready_hi = 0; busy_lo = 0; bad_data = 0;
        en_prev = 1'b0; got_done = 1'b0;
        chk({nm, "_rs"}, LCD_RS, rs);
        chk({nm, "_data"}, LCD_DATA, d);
        while (k <= exp_done + 20) begin
            if (LCD_EN) begin
                en_cnt++;
                if (LCD_DATA !== d || LCD_RS !== rs || LCD_RW !== 1'b0) bad_data++;
                if (!en_prev) begin
                    rises++;
                    if (en_first == 0) en_first = k;
                end
            end
            en_prev = LCD_EN;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (cmd_ready) ready_hi++;
            if (!busy) busy_lo++;
            k++;
            @(negedge Clock);
        end
        chk({nm, "_done_seen"}, got_done, 1);
        chk({nm, "_done_cycle"}, k, exp_done);
        chk({nm, "_en_rise_cycle"}, en_first, SETUP + 1);
        chk({nm, "_en_width"}, en_cnt, ENC);
        chk({nm, "_en_pulses"}, rises, 1);
        chk({nm, "_bus_during_en"}, bad_data, 0);
        chk({nm, "_ready_low"}, ready_hi, 0);
        chk({nm, "_busy_high"}, busy_lo, 0);
        chk({nm, "_busy_at_done"}, busy, 0);
        chk({nm, "_ready_at_done"}, cmd_ready, 1);
    endtask

    initial begin
        logic [7:0] b2b[3];
        int exp_done;
        int rises;
        logic en_prev, saw_en;

        vecs[0] = '{1'b1, 8'h41, 1'b0, "data_41"};
        vecs[1] = '{1'b0, 8'h01, 1'b1, "clear_01"};
        vecs[2] = '{1'b0, 8'h03, 1'b1, "home_03"};
        vecs[3] = '{1'b0, 8'h04, 1'b0, "entry_04"};
        vecs[4] = '{1'b1, 8'h01, 1'b0, "data_01"};
        vecs[5] = '{1'b0, 8'h80, 1'b0, "ddram_80"};
        vecs[6] = '{1'b0, 8'h02, 1'b1, "home_02"};

        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_rs    = 1'b0;
        cmd_data  = 8'h00;
`ifdef LCD_BUSY_POLL_EN
        rd_rises  = 0;
`endif
        repeat (3) @(negedge Clock);
        chk("rst_en", LCD_EN, 0);
        chk("rst_rs", LCD_RS, 0);
        chk("rst_rw", LCD_RW, 0);
        chk("rst_data", LCD_DATA, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef LCD_BUSY_POLL_EN
        chk("rst_oe", lcd_data_oe, 1);
        chk("rst_timeout", poll_timeout, 0);
`endif
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_ready", cmd_ready, 1);

`ifndef LCD_BUSY_POLL_EN
        // Single requests: normal vs long execution wait.
        for (int i = 0; i < 7; i++) begin
            exp_done = SETUP + ENC + HOLD + (vecs[i].is_long ? LONG : EXEC) + 1;
            send(vecs[i].rs, vecs[i].data, vecs[i].name);
            watch(vecs[i].rs, vecs[i].data, exp_done, vecs[i].name);
            @(negedge Clock);
            chk({vecs[i].name, "_done_1cyc"}, done, 0);
            chk({vecs[i].name, "_idle_hold_data"}, LCD_DATA, vecs[i].data);
            chk({vecs[i].name, "_idle_ready"}, cmd_ready, 1);
        end

        // Back-to-back: valid held high, each byte accepted on the done cycle.
        b2b[0] = 8'h48; b2b[1] = 8'h49; b2b[2] = 8'h4A;
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = b2b[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk($sformatf("b2b%0d_accepted", i), cmd_ready, 0);
            if (i < 2) cmd_data = b2b[i + 1];
            else cmd_valid = 1'b0;
            watch(1'b1, b2b[i], SETUP + ENC + HOLD + EXEC + 1, $sformatf("b2b%0d", i));
        end
        @(negedge Clock);
        chk("b2b_end_done", done, 0);
        chk("b2b_end_busy", busy, 0);
`else
        // Busy-flag polling: one write pulse, then four reads (3 busy + release).
        begin
            int k, wr_rises, oe_bad;
            logic got_done;
            k = 1; wr_rises = 0; oe_bad = 0; got_done = 1'b0; en_prev = 1'b0;
            send(1'b1, 8'h41, "poll");
            while (k <= 300) begin
                if (LCD_EN && !en_prev) begin
                    if (LCD_RW) rd_rises++;
                    else wr_rises++;
                end
                en_prev = LCD_EN;
                if (LCD_RW && (lcd_data_oe !== 1'b0 || LCD_RS !== 1'b0)) oe_bad++;
                if (done) begin
                    got_done = 1'b1;
                    break;
                end
                k++;
                @(negedge Clock);
            end
            chk("poll_done_seen", got_done, 1);
            chk("poll_done_cycle", k, (SETUP + ENC + HOLD) * 5 + 1);
            chk("poll_write_pulses", wr_rises, 1);
            chk("poll_read_pulses", rd_rises, 4);
            chk("poll_oe_rs_during_read", oe_bad, 0);
            chk("poll_rw_after", LCD_RW, 0);
            chk("poll_oe_after", lcd_data_oe, 1);
            chk("poll_timeout", poll_timeout, 0);
            chk("poll_ready_after", cmd_ready, 1);
            @(negedge Clock);
        end
`endif

        // Reset during EN_HI: EN drops at once, byte lost, no further pulse.
        send(1'b1, 8'h55, "rst_mid");
        saw_en = 1'b0;
        for (int i = 0; i < 20 && !saw_en; i++) begin
            if (LCD_EN) saw_en = 1'b1;
            else @(negedge Clock);
        end
        chk("rst_mid_en_reached", saw_en, 1);
        Reset = 1'b1;
        #1;
        chk("rst_mid_en_async", LCD_EN, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_mid_en", LCD_EN, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_data", LCD_DATA, 0);
        rises = 0;
        en_prev = 1'b0;
        for (int i = 0; i < EXEC + 100; i++) begin
            if (LCD_EN && !en_prev) rises++;
            en_prev = LCD_EN;
            @(negedge Clock);
        end
        chk("rst_mid_no_pulse", rises, 0);
        chk("rst_mid_no_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
